// File: rtl/ring_pkg.sv
// Shared types and default sizes for the ring sequencer.
package ring_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ring_rot.sv
// One-position ring rotation: dir = 0 rotates towards bit 0, dir = 1 towards the MSB.
module ring_rot #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    output logic [WIDTH-1:0] q_rot
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign q_rot[gi] = dir ? q[(gi + WIDTH - 1) % WIDTH] : q[(gi + 1) % WIDTH];
    end

endmodule

// File: rtl/ring_seq_ctrl.sv
// Command-driven ring rotator with step counting, abort and done pulse.
// Optional RING_BOUNCE_EN: reverse direction at the ring ends instead of wrapping.
module ring_seq_ctrl
    import ring_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             tick,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_load,
    input  logic [WIDTH-1:0] cmd_pattern,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] RING_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   q_reg, q_next, q_rot, load_val;
    logic [CNT_W-1:0]   remaining_reg, remaining_next;
    logic               dir_reg, dir_next, step_dir;

    // An all-zero ring would never show activity, so it is replaced by a single one.
    assign load_val = (cmd_pattern == '0) ? RING_ONE : cmd_pattern;

`ifdef RING_BOUNCE_EN
    assign step_dir = dir_reg ^ (dir_reg ? q_reg[WIDTH-1] : q_reg[0]);
`else
    assign step_dir = dir_reg;
`endif

    ring_rot #(.WIDTH(WIDTH)) u_rot (
        .q     (q_reg),
        .dir   (step_dir),
        .q_rot (q_rot)
    );

    always_comb begin
        state_next     = state_reg;
        q_next         = q_reg;
        remaining_next = remaining_reg;
        dir_next       = dir_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    dir_next       = cmd_dir;
                    remaining_next = cmd_steps;
                    if (cmd_load) q_next = load_val;
                    state_next = (cmd_steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Abort wins over a coincident tick: no rotation, no done pulse.
                if (abort) begin
                    state_next = IDLE;
                end else if (tick) begin
                    q_next         = q_rot;
                    dir_next       = step_dir;
                    remaining_next = remaining_reg - 1'b1;
                    if (remaining_reg == CNT_W'(1)) state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_reg     <= IDLE;
            q_reg         <= RING_ONE;
            remaining_reg <= '0;
            dir_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            q_reg         <= q_next;
            remaining_reg <= remaining_next;
            dir_reg       <= dir_next;
        end
    end

    assign q         = q_reg;
    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg == RUN);
    assign done      = (state_reg == DONE);

endmodule
